// File: rtl/enemy_attack_scheduler.sv
// enemy_attack_scheduler: frame-aligned round-robin arbiter for the shared
// enemy-attack sprite/ROM path. One requester holds the grant for
// ATTACK_FRAMES game frames, then the path idles for COOLDOWN_FRAMES frames.
//
// Handshake: Attack_Req is a level request sampled only on a game-frame tick
// while IDLE; Grant is the registered one-hot acknowledge, is held for the
// whole attack regardless of Attack_Req, and cannot be refused.
module enemy_attack_scheduler #(
  parameter int N_REQ           = 4,
  parameter int ADDR_W          = 9,
  parameter int ATTACK_FRAMES   = 30,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    game_frame_clk_rising_edge,
  input  logic                    Game_Start_On,
  input  logic                    Game_Over_On,
  input  logic [N_REQ-1:0]        Attack_Req,
  input  logic [N_REQ*ADDR_W-1:0] Req_address,
  input  logic [N_REQ-1:0]        Req_is_obj,
  output logic [N_REQ-1:0]        Grant,
  output logic                    Grant_Valid,
  output logic [2:0]              Grant_Id,
  output logic                    Grant_Start,
  output logic [ADDR_W-1:0]       Sel_address,
  output logic                    Sel_is_obj,
  output logic                    Busy,
  output logic [7:0]              Attack_Count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  // Counter reload values; the cooldown one is unused when COOLDOWN_FRAMES is 0.
  localparam logic [7:0] ATTACK_LOAD = 8'(ATTACK_FRAMES - 1);
  localparam logic [7:0] COOL_LOAD   = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [3:0] N_REQ_L     = 4'(N_REQ);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [2:0]       rr_ptr, rr_ptr_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [2:0]       grant_id_nxt;
  logic             grant_start_nxt;
  logic [7:0]       count_nxt;
  logic             halt;
  logic             tick;
  logic             win_found;
  logic [2:0]       win_id;
  logic [N_REQ-1:0] win_onehot;
  logic [2:0]       win_next_ptr;
  logic [7:0]       req_ext;

  assign halt        = Game_Over_On | Game_Start_On;
  assign tick        = game_frame_clk_rising_edge;
  assign req_ext     = 8'(Attack_Req);
  assign Grant_Valid = |Grant;
  assign Busy        = (state != IDLE);

  // Cyclic search for the first set request starting at rr_ptr.
  always_comb begin
    logic [3:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= N_REQ_L) idx = idx - N_REQ_L;
      if (!win_found && req_ext[idx[2:0]]) begin
        win_found = 1'b1;
        win_id    = idx[2:0];
      end
    end
  end

  // One-hot form of the winner and the pointer position just past it.
  always_comb begin
    logic [3:0] nxt;
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = (3'(i) == win_id);
    end
    nxt = {1'b0, win_id} + 4'd1;
    if (nxt >= N_REQ_L) nxt = 4'd0;
    win_next_ptr = nxt[2:0];
  end

  // Next-state and registered-output logic; halt overrides everything.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    rr_ptr_nxt      = rr_ptr;
    grant_nxt       = Grant;
    grant_id_nxt    = Grant_Id;
    grant_start_nxt = 1'b0;
    count_nxt       = Attack_Count;
    if (halt) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      grant_nxt    = '0;
      grant_id_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && win_found) begin
            state_nxt       = ACTIVE;
            grant_nxt       = win_onehot;
            grant_id_nxt    = win_id;
            grant_start_nxt = 1'b1;
            cnt_nxt         = ATTACK_LOAD;
            rr_ptr_nxt      = win_next_ptr;
            if (Attack_Count != 8'hFF) count_nxt = Attack_Count + 8'd1;
          end
        end
        ACTIVE: begin
          if (tick) begin
            if (cnt == 8'd0) begin
              grant_nxt    = '0;
              grant_id_nxt = '0;
              if (COOLDOWN_FRAMES == 0) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
              end else begin
                state_nxt = COOLDOWN;
                cnt_nxt   = COOL_LOAD;
              end
            end else begin
              cnt_nxt = cnt - 8'd1;
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cnt == 8'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 8'd1;
          end
        end
        default: begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          grant_id_nxt = '0;
        end
      endcase
    end
  end

  // State, counters and registered grant outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= '0;
      Grant        <= '0;
      Grant_Id     <= '0;
      Grant_Start  <= 1'b0;
      Attack_Count <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rr_ptr       <= rr_ptr_nxt;
      Grant        <= grant_nxt;
      Grant_Id     <= grant_id_nxt;
      Grant_Start  <= grant_start_nxt;
      Attack_Count <= count_nxt;
    end
  end

  // AND-OR mux of the granted requester onto the shared ROM path, unregistered.
  always_comb begin
    Sel_address = '0;
    Sel_is_obj  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      Sel_address = Sel_address | (Req_address[i*ADDR_W +: ADDR_W] & {ADDR_W{Grant[i]}});
      Sel_is_obj  = Sel_is_obj | (Req_is_obj[i] & Grant[i]);
    end
  end

endmodule

// File: tb/tb_enemy_attack_scheduler.sv
// Testbench for enemy_attack_scheduler: a default-parameter instance (30/15)
// and a fast instance (1/0), driven with shared stimulus.
module tb_enemy_attack_scheduler;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        tick;
  logic        Game_Start_On;
  logic        Game_Over_On;
  logic [3:0]  Attack_Req;
  logic [35:0] Req_address;
  logic [3:0]  Req_is_obj;

  logic [3:0] g, s_g;
  logic       gv, s_gv;
  logic [2:0] gid, s_gid;
  logic       gs, s_gs;
  logic [8:0] sa, s_sa;
  logic       so, s_so;
  logic       busy, s_busy;
  logic [7:0] cnt, s_cnt;

  logic [8:0] addr_tab [4];

  enemy_attack_scheduler #(.N_REQ(4), .ADDR_W(9), .ATTACK_FRAMES(30), .COOLDOWN_FRAMES(15)) dut (
    .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(tick),
    .Game_Start_On(Game_Start_On), .Game_Over_On(Game_Over_On),
    .Attack_Req(Attack_Req), .Req_address(Req_address), .Req_is_obj(Req_is_obj),
    .Grant(g), .Grant_Valid(gv), .Grant_Id(gid), .Grant_Start(gs),
    .Sel_address(sa), .Sel_is_obj(so), .Busy(busy), .Attack_Count(cnt)
  );

  enemy_attack_scheduler #(.N_REQ(4), .ADDR_W(9), .ATTACK_FRAMES(1), .COOLDOWN_FRAMES(0)) dut_sat (
    .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(tick),
    .Game_Start_On(Game_Start_On), .Game_Over_On(Game_Over_On),
    .Attack_Req(Attack_Req), .Req_address(Req_address), .Req_is_obj(Req_is_obj),
    .Grant(s_g), .Grant_Valid(s_gv), .Grant_Id(s_gid), .Grant_Start(s_gs),
    .Sel_address(s_sa), .Sel_is_obj(s_so), .Busy(s_busy), .Attack_Count(s_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] id_of(input logic [3:0] oh);
    id_of = 3'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) id_of = 3'(i);
  endfunction

  function automatic logic [8:0] addr_of(input logic [3:0] oh);
    addr_of = 9'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) addr_of = addr_tab[i];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Tick sampled on the next edge; returns 1 time unit after that edge.
  task automatic tick_cycle();
    tick = 1'b1;
    @(posedge Clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic frame();
    idle(2);
    tick_cycle();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    idle(2);
    Reset = 1'b0;
    idle(1);
  endtask

  // ---------------- vector table (fast instance) ----------------
  typedef struct {
    logic [3:0] req;
    logic       over;
    logic       start;
    logic [3:0] grant;
    logic       busy;
    logic       gstart;
    logic [7:0] count;
  } vec_t;

  vec_t tab [18];

  initial begin
    tab[0]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 8'd1};
    tab[1]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd1};
    tab[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 8'd2};
    tab[3]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd2};
    tab[4]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 8'd3};
    tab[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd3};
    tab[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 8'd4};
    tab[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd4};
    tab[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 8'd5};
    tab[9]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd5};
    tab[10] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 8'd6};
    tab[11] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd6};
    tab[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd6};
    tab[13] = '{4'b1001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd6};
    tab[14] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 8'd7};
    tab[15] = '{4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd7};
    tab[16] = '{4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 8'd8};
    tab[17] = '{4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd8};
  end

  // ---------------- test sequence ----------------
  initial begin
    addr_tab[0] = 9'h011;
    addr_tab[1] = 9'h0A2;
    addr_tab[2] = 9'h153;
    addr_tab[3] = 9'h1E4;
    Req_address   = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    Req_is_obj    = 4'b0110;
    Reset         = 1'b1;
    tick          = 1'b0;
    Game_Start_On = 1'b0;
    Game_Over_On  = 1'b0;
    Attack_Req    = 4'b0000;
    idle(2);

    // Reset state
    check("rst_grant", g, 4'b0);
    check("rst_valid", gv, 1'b0);
    check("rst_id", gid, 3'd0);
    check("rst_start", gs, 1'b0);
    check("rst_sel_addr", sa, 9'd0);
    check("rst_sel_obj", so, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", cnt, 8'd0);
    Reset = 1'b0;
    idle(1);

    // Table: round-robin, halt handling, start pulse (fast instance)
    for (int i = 0; i < 18; i++) begin
      Attack_Req    = tab[i].req;
      Game_Over_On  = tab[i].over;
      Game_Start_On = tab[i].start;
      tick_cycle();
      check($sformatf("vec%0d_grant", i), s_g, tab[i].grant);
      check($sformatf("vec%0d_valid", i), s_gv, |tab[i].grant);
      check($sformatf("vec%0d_id", i), s_gid, id_of(tab[i].grant));
      check($sformatf("vec%0d_busy", i), s_busy, tab[i].busy);
      check($sformatf("vec%0d_start", i), s_gs, tab[i].gstart);
      check($sformatf("vec%0d_count", i), s_cnt, tab[i].count);
      check($sformatf("vec%0d_sel_addr", i), s_sa, addr_of(tab[i].grant));
    end
    Game_Over_On  = 1'b0;
    Game_Start_On = 1'b0;

    // Grant timing with 30 attack / 15 cooldown frames
    do_reset();
    Attack_Req = 4'b0010;
    idle(5);
    check("no_tick_no_grant", g, 4'b0);
    frame();
    check("first_grant", g, 4'b0010);
    check("first_id", gid, 3'd1);
    check("first_start", gs, 1'b1);
    check("first_valid", gv, 1'b1);
    check("first_busy", busy, 1'b1);
    check("first_count", cnt, 8'd1);
    check("first_sel_addr", sa, 9'h0A2);
    check("first_sel_obj", so, 1'b1);
    idle(1);
    check("start_one_cycle", gs, 1'b0);
    check("grant_after_start", g, 4'b0010);
    for (int t = 1; t <= 29; t++) begin
      frame();
      check($sformatf("hold_tick%0d", t), g, 4'b0010);
    end
    frame();
    check("tick30_grant_clear", g, 4'b0);
    check("tick30_busy", busy, 1'b1);
    check("tick30_sel_addr", sa, 9'd0);
    for (int t = 31; t <= 44; t++) begin
      frame();
      check($sformatf("cool_tick%0d_busy", t), busy, 1'b1);
      check($sformatf("cool_tick%0d_grant", t), g, 4'b0);
    end
    frame();
    check("tick45_busy", busy, 1'b0);
    check("tick45_grant", g, 4'b0);
    frame();
    check("tick46_grant", g, 4'b0010);
    check("tick46_start", gs, 1'b1);
    check("tick46_count", cnt, 8'd2);

    // Request dropped mid-grant: grant is committed
    do_reset();
    Attack_Req = 4'b0100;
    frame();
    check("drop_grant", g, 4'b0100);
    check("drop_sel_addr", sa, 9'h153);
    check("drop_sel_obj", so, 1'b1);
    Attack_Req = 4'b0000;
    for (int t = 1; t <= 29; t++) begin
      frame();
      check($sformatf("drop_hold%0d", t), g, 4'b0100);
    end
    frame();
    check("drop_end_grant", g, 4'b0);
    check("drop_end_busy", busy, 1'b1);

    // Game over mid-ACTIVE together with a tick
    do_reset();
    Attack_Req = 4'b0001;
    frame();
    check("halt_pre_grant", g, 4'b0001);
    frame();
    frame();
    Game_Over_On = 1'b1;
    frame();
    check("halt_grant", g, 4'b0);
    check("halt_busy", busy, 1'b0);
    check("halt_valid", gv, 1'b0);
    Attack_Req = 4'b1111;
    for (int t = 0; t < 3; t++) begin
      frame();
      check($sformatf("halted_grant%0d", t), g, 4'b0);
    end
    Game_Over_On = 1'b0;
    Attack_Req   = 4'b0001;
    frame();
    check("release_grant", g, 4'b0001);
    check("release_count", cnt, 8'd2);

    // Saturation of Attack_Count (fast instance), then async reset mid-grant
    do_reset();
    Attack_Req = 4'b0001;
    for (int t = 0; t < 200; t++) tick_cycle();
    check("sat_count_100", s_cnt, 8'd100);
    for (int t = 200; t < 512; t++) tick_cycle();
    check("sat_count_255", s_cnt, 8'd255);
    tick_cycle();
    check("sat_grant", s_g, 4'b0001);
    check("sat_count_held", s_cnt, 8'd255);
    #2;
    Reset = 1'b1;
    #1;
    check("async_grant", s_g, 4'b0);
    check("async_valid", s_gv, 1'b0);
    check("async_id", s_gid, 3'd0);
    check("async_start", s_gs, 1'b0);
    check("async_busy", s_busy, 1'b0);
    check("async_count", s_cnt, 8'd0);
    check("async_sel_addr", s_sa, 9'd0);
    check("async_sel_obj", s_so, 1'b0);
    check("async_main_grant", g, 4'b0);
    idle(2);
    Reset = 1'b0;
    idle(2);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_attack_scheduler.md
Name: enemy_attack_scheduler

Overview:
- Frame-aligned round-robin scheduler that grants the single shared enemy-attack sprite/ROM path to one of the enemy requesters at a time.
- It holds the grant for a fixed number of game frames, then enforces a cooldown before the next grant.
- It muxes the granted requester's sprite address and is_obj onto the shared enemy_attackROM path.
- It sits between the per-enemy enemy_attack instances and the enemy_attackROM / color_mapper. It replaces the fixed-priority select, which starves higher-numbered enemies.

Parameters:
- N_REQ, 4, number of enemy requesters (2..8).
- ADDR_W, 9, width of each requester's sprite ROM address.
- ATTACK_FRAMES, 30, game frames a grant is held (1..255).
- COOLDOWN_FRAMES, 15, game frames idle after a grant (0..255).

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset  input  1  asynchronous, active-high reset.
- game_frame_clk_rising_edge  input  1  one-cycle game frame tick.
- Game_Start_On  input  1  start screen shown; halts scheduling.
- Game_Over_On  input  1  game over; halts scheduling.
- Attack_Req  input  N_REQ  per-enemy attack request (level; Enemy_Attack_Ready).
- Req_address  input  N_REQ*ADDR_W  packed per-requester ROM addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- Req_is_obj  input  N_REQ  per-requester is_obj.
- Grant  output  N_REQ  one-hot grant; registered.
- Grant_Valid  output  1  OR of Grant.
- Grant_Id  output  3  index of granted requester; 0 when none.
- Grant_Start  output  1  one-cycle pulse in the first cycle Grant is asserted.
- Sel_address  output  ADDR_W  Req_address of granted requester; 0 when none (combinational from Grant).
- Sel_is_obj  output  1  Req_is_obj of granted requester; 0 when none.
- Busy  output  1  state != IDLE.
- Attack_Count  output  8  number of grants issued; saturates at 255.

Behaviour:
- Reset values:
  - state IDLE; Grant 0; Grant_Valid 0; Grant_Id 0; Grant_Start 0; Busy 0; Attack_Count 0.
  - rr_ptr 0; frame counter cnt (8-bit) 0.
  - Sel_address 0; Sel_is_obj 0.
- Halt condition: Game_Over_On or Game_Start_On.
  - While halted, next state is IDLE from any state, Grant is cleared next cycle and no grant is issued.
  - rr_ptr and Attack_Count are retained.
  - Halt takes priority over a tick in the same cycle.
- IDLE:
  - On a cycle with tick=1, not halted and Attack_Req != 0: the winner is the first set request searching cyclically from rr_ptr upward.
  - Next cycle: Grant = onehot(winner), Grant_Start=1, cnt = ATTACK_FRAMES-1, rr_ptr = (winner+1) mod N_REQ, Attack_Count++ (saturating), state ACTIVE.
  - Requests without a tick are ignored; no grant between ticks.
- ACTIVE:
  - Grant is held even if the winner drops Attack_Req (attack is committed).
  - On each tick: if cnt==0, Grant clears next cycle and the state moves to COOLDOWN with cnt=COOLDOWN_FRAMES-1, or to IDLE if COOLDOWN_FRAMES==0. Otherwise cnt--.
  - Net effect: Grant is high for exactly ATTACK_FRAMES ticks, deasserting in the cycle after the ATTACK_FRAMES-th tick following the granting tick.
- COOLDOWN: on each tick, if cnt==0 go to IDLE, else cnt--. A new grant is possible only on a tick seen in IDLE, so the gap between grants is ≥ COOLDOWN_FRAMES+1 ticks.
- Latency: grant is visible 1 clock after the deciding tick.
- Sel mux: pure combinational AND-OR of the Grant one-hot. No extra register, so the ROM's 1-cycle read latency is unchanged.
- Grant_Start: high only in the first cycle of a grant, never otherwise.
- A reset asserted mid-ACTIVE clears the grant asynchronously.
- N_REQ=1 degenerates to grant/cooldown cycling of requester 0.

Test Plan:
- Reset, then Attack_Req=4'b0010 with a tick → next cycle Grant=0010, Grant_Id=1, Grant_Start=1 for 1 cycle, Attack_Count=1, Sel_address=Req_address[1].
- Hold ATTACK_FRAMES=30 and COOLDOWN_FRAMES=15 → Grant stays 0010 through 29 further ticks. It clears the cycle after tick 30. Busy stays high for 15 more ticks, and the next grant is possible only on tick 46.
- Attack_Req=4'b1111 held continuously → successive grants are 0001, 0010, 0100, 1000, 0001 (round-robin, no starvation).
- Grant active for req 2, then Attack_Req drops to 0 mid-grant → Grant remains 0100 for the full 30 ticks.
- Game_Over_On=1 mid-ACTIVE while a tick arrives in the same cycle → next cycle Grant=0, Busy=0. No grant while halted. After release with Attack_Req=0001 and a tick → Grant=0001.
- Force 256 grants with ATTACK_FRAMES=1, COOLDOWN_FRAMES=0 → Attack_Count stops at 255. Async Reset asserted mid-grant → all outputs 0 immediately.
